cache_ctrl: RTL and testbench

Cache controller between the MOSby CPU bus and the 128-byte direct-mapped cache plus main memory. Services each CPU read by looking it up in the cache and filling the line from main memory on a miss; writes go through to memory and also allocate in the cache. Owns all sequencing of the cache's address-event write protocol, so the CPU sees a simple request/ready handshake. Also keeps saturating hit/miss statistics.

---
 rtl/cache_ctrl.sv | 133 +++++++++++++
 tb/tb_cache_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: CPU-side controller for a 128-line direct-mapped cache with write-through/allocate
module cache_ctrl (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  output logic [15:0] c_addr,
  output logic        c_w_rd,
  output logic [7:0]  c_wdata,
  input  logic [7:0]  c_rdata,
  input  logic        c_hit,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, PARK, ARM, COMMIT, RESP} state_t;
  state_t      r_state;
  logic [15:0] r_a, r_c_addr, r_mem_addr, r_hit_cnt, r_miss_cnt;
  logic [7:0]  r_fill, r_cpu_rdata, r_c_wdata, r_mem_wdata;
  logic        r_cpu_ready, r_c_w_rd, r_mem_req, r_mem_we;
  logic        w_hit, w_lookup_hit, w_lookup_miss;

  // An X or Z hit flag from an unwritten line must count as a miss
  assign w_hit         = (c_hit === 1'b1);
  assign w_lookup_hit  = (r_state == LOOKUP) && w_hit;
  assign w_lookup_miss = (r_state == LOOKUP) && !w_hit;

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign c_addr    = r_c_addr;
  assign c_w_rd    = r_c_w_rd;
  assign c_wdata   = r_c_wdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;

  // Sequencer; every output is set on the edge that enters the state it belongs to
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_fill      <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ready <= 1'b0;
      r_c_addr    <= '0;
      r_c_w_rd    <= 1'b0;
      r_c_wdata   <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: if (cpu_req) begin
          r_a <= cpu_addr;
          if (cpu_we) begin
            r_fill      <= cpu_wdata;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= cpu_addr;
            r_mem_wdata <= cpu_wdata;
            r_state     <= MEM_WR;
          end else begin
            r_c_w_rd <= 1'b0;
            r_c_addr <= cpu_addr;
            r_state  <= LOOKUP;
          end
        end
        LOOKUP: if (w_hit) begin
          r_cpu_rdata <= c_rdata;
          r_cpu_ready <= 1'b1;
          r_state     <= RESP;
        end else begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_a;
          r_state    <= MEM_RD;
        end
        MEM_RD, MEM_WR: if (mem_ack) begin
          if (r_state == MEM_RD) begin
            r_fill      <= mem_rdata;
            r_cpu_rdata <= mem_rdata;
          end
          r_mem_req <= 1'b0;
          r_c_w_rd  <= 1'b0;
          r_c_addr  <= ~r_a;
          r_state   <= PARK;
        end
        PARK: begin
          r_c_w_rd  <= 1'b1;
          r_c_wdata <= r_fill;
          r_state   <= ARM;
        end
        ARM: begin
          r_c_addr <= r_a;
          r_state  <= COMMIT;
        end
        COMMIT: begin
          r_c_w_rd    <= 1'b0;
          r_cpu_ready <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          r_cpu_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Saturating read statistics, updated from the lookup outcome
  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_hit_cnt  <= r_hit_cnt + {15'd0, w_lookup_hit && (r_hit_cnt != 16'hFFFF)};
      r_miss_cnt <= r_miss_cnt + {15'd0, w_lookup_miss && (r_miss_cnt != 16'hFFFF)};
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed tests of cache_ctrl against a cache and memory model
module tb_cache_ctrl;
  logic        clk_1 = 1'b0, rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata, c_wdata, c_rdata, mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        cpu_ready, c_w_rd, c_hit, mem_req, mem_we, mem_ack;
  logic [15:0] c_addr, mem_addr, hit_cnt, miss_cnt;
  logic        m_ack = 1'b0, spur = 1'b0;
  int          total = 0, bad = 0, w = 0, m_cnt = 0, acks = 0, proto_err = 0;
  logic [15:0] ack_addr = '0, p_addr = '0;
  logic        ack_we = 1'b0, p_wrd = 1'b0;
  logic [7:0]  ack_wdata = '0;
  logic [7:0]  mem [0:65535];
  logic [7:0]  cd [0:127];
  logic [8:0]  ct [0:127];
  logic        cv [0:127];

  assign mem_ack = m_ack | spur;
  assign c_rdata = cd[c_addr[6:0]];
  assign c_hit   = cv[c_addr[6:0]] && (ct[c_addr[6:0]] == c_addr[15:7]);

  cache_ctrl dut (
    .clk_1(clk_1), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .c_addr(c_addr),
    .c_w_rd(c_w_rd), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_hit(c_hit), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk_1 = ~clk_1;

  // Cache writes only on an address event while c_w_rd is already high
  always @(c_addr) begin
    if (c_w_rd) begin
      cd[c_addr[6:0]] = c_wdata;
      ct[c_addr[6:0]] = c_addr[15:7];
      cv[c_addr[6:0]] = 1'b1;
    end
  end

  // Memory acknowledges in the (w+1)-th cycle of a request
  always @(negedge clk_1) begin
    if (!mem_req) begin
      m_ack = 1'b0;
      m_cnt = 0;
    end else if (!m_ack) begin
      if (m_cnt == w) begin
        m_ack     = 1'b1;
        mem_rdata = mem[mem_addr];
        ack_addr  = mem_addr;
        ack_we    = mem_we;
        ack_wdata = mem_wdata;
        if (mem_we) mem[mem_addr] = mem_wdata;
        acks++;
      end else m_cnt++;
    end
  end

  // Records any cycle where c_w_rd and c_addr change together
  always @(negedge clk_1) begin
    if (rst && c_addr != p_addr && c_w_rd != p_wrd) proto_err++;
    p_addr = c_addr;
    p_wrd  = c_w_rd;
  end

  task automatic do_txn(input logic we, input logic [15:0] a, input logic [7:0] d, input logic jit,
                        output int lat, output logic [7:0] rd, output int wrc, output int mrq);
    @(negedge clk_1);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = 0; wrc = 0; mrq = 0;
    while (lat < 100) begin
      @(posedge clk_1); #1;
      lat++;
      if (c_w_rd) wrc++;
      if (mem_req) mrq++;
      if (cpu_ready) break;
      if (jit && lat >= 2) begin
        cpu_req  = ~cpu_req;
        cpu_addr = cpu_addr + 16'h0101;
      end
    end
    rd = cpu_rdata;
    cpu_req = 1'b0;
    @(posedge clk_1); #1;
  endtask

  task automatic test_reset();
    int rc, mq;
    rst = 1'b1; #2 rst = 1'b0;
    repeat (3) @(posedge clk_1); #1;
    total++; if ({cpu_ready, cpu_rdata, c_addr, c_w_rd, c_wdata} !== '0) begin bad++; $display("FAIL reset_cpu_cache got=%h want=0", {cpu_ready, cpu_rdata, c_addr, c_w_rd, c_wdata}); end
    total++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin bad++; $display("FAIL reset_mem got=%h want=0", {mem_req, mem_we, mem_addr, mem_wdata}); end
    total++; if ({hit_cnt, miss_cnt} !== '0) begin bad++; $display("FAIL reset_cnt got=%h want=0", {hit_cnt, miss_cnt}); end
    @(negedge clk_1) rst = 1'b1;
    w = 20;
    @(negedge clk_1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0777;
    @(posedge clk_1); #1; cpu_req = 1'b0;
    @(posedge clk_1); #1;
    total++; if ({mem_req, mem_addr, miss_cnt} !== {1'b1, 16'h0777, 16'd1}) begin bad++; $display("FAIL abort_setup got=%h want=%h", {mem_req, mem_addr, miss_cnt}, {1'b1, 16'h0777, 16'd1}); end
    @(posedge clk_1); #2 rst = 1'b0; #1;
    total++; if ({mem_req, mem_we, mem_addr, c_addr, miss_cnt} !== '0) begin bad++; $display("FAIL abort_reset got=%h want=0", {mem_req, mem_we, mem_addr, c_addr, miss_cnt}); end
    @(negedge clk_1) rst = 1'b1;
    rc = 0; mq = 0;
    repeat (10) begin
      @(posedge clk_1); #1;
      if (cpu_ready) rc++;
      if (mem_req) mq++;
    end
    total++; if (rc + mq != 0) begin bad++; $display("FAIL abort_quiet ready=%0d mem_req=%0d want=0", rc, mq); end
  endtask

  task automatic test_miss_hit();
    int lat, wrc, mrq, a0;
    logic [7:0] rd;
    w = 2; a0 = acks;
    do_txn(1'b0, 16'h1234, 8'h00, 1'b0, lat, rd, wrc, mrq);
    total++; if (lat != 8) begin bad++; $display("FAIL miss_latency got=%0d want=8", lat); end
    total++; if (rd !== 8'hA5) begin bad++; $display("FAIL miss_rdata got=%h want=a5", rd); end
    total++; if (miss_cnt !== 16'd1) begin bad++; $display("FAIL miss_cnt got=%0d want=1", miss_cnt); end
    total++; if (wrc != 2) begin bad++; $display("FAIL miss_cwrd_cycles got=%0d want=2", wrc); end
    total++; if (acks - a0 != 1 || ack_addr !== 16'h1234) begin bad++; $display("FAIL miss_mem got=%0d/%h want=1/1234", acks - a0, ack_addr); end
    do_txn(1'b0, 16'h1234, 8'h00, 1'b0, lat, rd, wrc, mrq);
    total++; if (lat != 2) begin bad++; $display("FAIL hit_latency got=%0d want=2", lat); end
    total++; if (rd !== 8'hA5) begin bad++; $display("FAIL hit_rdata got=%h want=a5", rd); end
    total++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin bad++; $display("FAIL hit_cnt got=%0d/%0d want=1/1", hit_cnt, miss_cnt); end
    total++; if (mrq != 0 || wrc != 0) begin bad++; $display("FAIL hit_traffic got=%0d/%0d want=0/0", mrq, wrc); end
  endtask

  task automatic test_conflict();
    int lat, wrc, mrq;
    logic [7:0] rd;
    w = 0;
    do_txn(1'b0, 16'h5634, 8'h00, 1'b0, lat, rd, wrc, mrq);
    total++; if (lat != 6 || rd !== 8'h5B) begin bad++; $display("FAIL conflict_a got=%0d/%h want=6/5b", lat, rd); end
    do_txn(1'b0, 16'h1234, 8'h00, 1'b0, lat, rd, wrc, mrq);
    total++; if (lat != 6 || rd !== 8'hA5) begin bad++; $display("FAIL conflict_b got=%0d/%h want=6/a5", lat, rd); end
    do_txn(1'b0, 16'h5634, 8'h00, 1'b0, lat, rd, wrc, mrq);
    total++; if (lat != 6 || rd !== 8'h5B) begin bad++; $display("FAIL conflict_c got=%0d/%h want=6/5b", lat, rd); end
    total++; if (miss_cnt !== 16'd4 || hit_cnt !== 16'd1) begin bad++; $display("FAIL conflict_cnt got=%0d/%0d want=4/1", miss_cnt, hit_cnt); end
  endtask

  task automatic test_write();
    int lat, wrc, mrq, a0;
    logic [7:0] rd;
    w = 1;
    do_txn(1'b1, 16'hBEEF, 8'h3C, 1'b0, lat, rd, wrc, mrq);
    total++; if (lat != 6) begin bad++; $display("FAIL write_latency got=%0d want=6", lat); end
    total++; if ({ack_we, ack_wdata, ack_addr} !== {1'b1, 8'h3C, 16'hBEEF}) begin bad++; $display("FAIL write_mem got=%h want=13cbeef", {ack_we, ack_wdata, ack_addr}); end
    total++; if (wrc != 2 || rd !== 8'h5B) begin bad++; $display("FAIL write_cache got=%0d/%h want=2/5b", wrc, rd); end
    total++; if (hit_cnt !== 16'd1 || miss_cnt !== 16'd4) begin bad++; $display("FAIL write_cnt got=%0d/%0d want=1/4", hit_cnt, miss_cnt); end
    a0 = acks;
    do_txn(1'b0, 16'hBEEF, 8'h00, 1'b0, lat, rd, wrc, mrq);
    total++; if (lat != 2 || rd !== 8'h3C) begin bad++; $display("FAIL write_readback got=%0d/%h want=2/3c", lat, rd); end
    total++; if (mrq != 0 || acks != a0 || hit_cnt !== 16'd2) begin bad++; $display("FAIL write_readback_traffic got=%0d/%0d/%0d want=0/0/2", mrq, acks - a0, hit_cnt); end
  endtask

  task automatic test_handshake();
    int lat, wrc, mrq;
    logic [7:0] rd;
    w = 3;
    do_txn(1'b0, 16'h2222, 8'h00, 1'b1, lat, rd, wrc, mrq);
    total++; if (lat != 9 || rd !== 8'h77) begin bad++; $display("FAIL jitter_read got=%0d/%h want=9/77", lat, rd); end
    total++; if (ack_addr !== 16'h2222 || miss_cnt !== 16'd5) begin bad++; $display("FAIL jitter_addr got=%h/%0d want=2222/5", ack_addr, miss_cnt); end
    do_txn(1'b0, 16'h2222, 8'h00, 1'b0, lat, rd, wrc, mrq);
    total++; if (lat != 2 || rd !== 8'h77 || hit_cnt !== 16'd3) begin bad++; $display("FAIL jitter_fill got=%0d/%h/%0d want=2/77/3", lat, rd, hit_cnt); end
    @(negedge clk_1) spur = 1'b1;
    repeat (2) @(negedge clk_1);
    spur = 1'b0;
    #1;
    total++; if ({mem_req, cpu_ready, c_w_rd, hit_cnt, miss_cnt} !== {3'b000, 16'd3, 16'd5}) begin bad++; $display("FAIL spurious_ack got=%h want=%h", {mem_req, cpu_ready, c_w_rd, hit_cnt, miss_cnt}, {3'b000, 16'd3, 16'd5}); end
    do_txn(1'b0, 16'h2222, 8'h00, 1'b0, lat, rd, wrc, mrq);
    total++; if (lat != 2 || rd !== 8'h77 || hit_cnt !== 16'd4) begin bad++; $display("FAIL after_spurious got=%0d/%h/%0d want=2/77/4", lat, rd, hit_cnt); end
    total++; if (proto_err != 0) begin bad++; $display("FAIL cwrd_caddr_same_cycle got=%0d want=0", proto_err); end
  endtask

  task automatic test_saturation();
    int lat, wrc, mrq;
    logic [7:0] rd;
    logic [15:0] exp;
    @(negedge clk_1) force dut.r_hit_cnt = 16'hFFFD;
    @(negedge clk_1) release dut.r_hit_cnt;
    #1;
    total++; if (hit_cnt !== 16'hFFFD) begin bad++; $display("FAIL sat_preload got=%h want=fffd", hit_cnt); end
    exp = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      exp = (exp == 16'hFFFF) ? exp : exp + 16'd1;
      do_txn(1'b0, 16'h2222, 8'h00, 1'b0, lat, rd, wrc, mrq);
      total++; if (hit_cnt !== exp) begin bad++; $display("FAIL sat_hit%0d got=%h want=%h", i, hit_cnt, exp); end
    end
    total++; if (miss_cnt !== 16'd5) begin bad++; $display("FAIL sat_miss got=%0d want=5", miss_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    for (int i = 0; i < 128; i++) begin
      cd[i] = '0; ct[i] = '0; cv[i] = 1'b0;
    end
    mem[16'h1234] = 8'hA5;
    mem[16'h5634] = 8'h5B;
    mem[16'h2222] = 8'h77;
    test_reset();
    test_miss_hit();
    test_conflict();
    test_write();
    test_handshake();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
